// File: rtl/seq_pkg.sv
// Shared types and widths for the countdown sequencer.
package seq_pkg;

    localparam int PHASE_W       = 3;
    localparam int SEC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control and countdown-side signal bundle for countdown_sequencer.
// master = controller/countdown environment, slave = the sequencer.
interface countdown_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int SEC_W      = seq_pkg::SEC_W_DEFAULT
);
    import seq_pkg::*;

    logic                        start;
    logic                        abort;
    logic [NUM_PHASES*SEC_W-1:0] phase_secs;
    logic                        cd_done;
    logic                        cd_en;
    logic [SEC_W-1:0]            cd_load;
    logic                        cd_clear;
    logic [PHASE_W-1:0]          phase;
    logic                        busy;
    logic                        seq_done;

    modport master (
        output start, abort, phase_secs, cd_done,
        input  cd_en, cd_load, cd_clear, phase, busy, seq_done
    );

    modport slave (
        input  start, abort, phase_secs, cd_done,
        output cd_en, cd_load, cd_clear, phase, busy, seq_done
    );

endinterface

// File: rtl/rise_detect.sv
// Purpose: one-bit rising-edge detector against a registered copy of the input.
// Latency: rise is combinational from d, valid in the same cycle d goes high.
// Backpressure: none; free-running.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Purpose: runs a latched list of phase durations back-to-back through the countdown block.
// Latency: start -> first cd_en in 2 cycles; done edge -> next cd_en in 2 cycles.
// Backpressure: none; start is ignored while busy, abort wins over start.
module countdown_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int SEC_W      = SEC_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_sequencer_if.slave bus
);

    localparam logic [PHASE_W-1:0] P_END  = PHASE_W'(NUM_PHASES);
    localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(NUM_PHASES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] p;
    logic [PHASE_W-1:0] p_nxt;
    logic [SEC_W-1:0]   dur [NUM_PHASES];
    logic [SEC_W-1:0]   cur_dur;
    logic               latch_en;
    logic               clear_q;
    logic               clear_nxt;
    logic               done_rise;

    rise_detect u_done_rise (
        .clk   (clk),
        .reset (reset),
        .d     (bus.cd_done),
        .rise  (done_rise)
    );

    // Decoded select keeps p == NUM_PHASES reading as zero without an out-of-range index.
    always_comb begin
        cur_dur = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (p == PHASE_W'(i)) begin
                cur_dur = dur[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        latch_en  = 1'b0;
        clear_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    latch_en  = 1'b1;
                    p_nxt     = '0;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (p == P_END) begin
                    state_nxt = ST_FINISH;
                end else if (cur_dur == '0) begin
                    p_nxt = p + 1'b1;
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    p_nxt     = p + 1'b1;
                    state_nxt = ST_CHECK;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (state != ST_IDLE && bus.abort) begin
            state_nxt = ST_IDLE;
            p_nxt     = '0;
            clear_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            p       <= '0;
            clear_q <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            p       <= p_nxt;
            clear_q <= clear_nxt;
            if (latch_en) begin
                for (int i = 0; i < NUM_PHASES; i++) begin
                    dur[i] <= bus.phase_secs[i*SEC_W +: SEC_W];
                end
            end
        end
    end

    assign bus.cd_en    = (state == ST_LOAD);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.seq_done = (state == ST_FINISH);
    assign bus.cd_clear = clear_q;
    assign bus.cd_load  = cur_dur;
    assign bus.phase    = (p > P_LAST) ? P_LAST : p;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboarded bench: expected cd_en / cd_clear / seq_done events are queued at stimulus time
// and a negedge monitor pops and compares them as the sequencer emits them.
module tb_countdown_sequencer;

    localparam int NP       = 4;
    localparam int SW       = 8;
    localparam int CLK_FREQ = 4;
    localparam int EV_EN    = 0;
    localparam int EV_CLR   = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
        int ph;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    logic use_model = 1'b1;
    logic done_drv  = 1'b0;
    logic mdl_done  = 1'b0;
    int   mdl_cnt   = 0;

    countdown_sequencer_if #(.NUM_PHASES(NP), .SEC_W(SW)) bus ();

    countdown_sequencer #(.NUM_PHASES(NP), .SEC_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.cd_done = use_model ? mdl_done : done_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Countdown stand-in: en loads secs*CLK_FREQ ticks, done rises at expiry and holds until en.
    always @(posedge clk) begin
        if (reset || bus.cd_clear) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else if (bus.cd_en) begin
            mdl_cnt  <= int'(bus.cd_load) * CLK_FREQ;
            mdl_done <= 1'b0;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end
    end

    function automatic logic [NP*SW-1:0] pk(input int a, input int b, input int c, input int d);
        return {SW'(d), SW'(c), SW'(b), SW'(a)};
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_EN:   return "cd_en";
            EV_CLR:  return "cd_clear";
            default: return "seq_done";
        endcase
    endfunction

    task automatic push(input int kind, input int c, input int val, input int ph);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        e.ph   = ph;
        exp_q.push_back(e);
    endtask

    task automatic seen(input int kind, input int val, input int ph);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got cyc=%0d load=%0d phase=%0d, required no event",
                     kname(kind), cyc, val, ph);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val || e.ph != ph) begin
                bad++;
                $display("FAIL event_%s: got %s cyc=%0d load=%0d phase=%0d, required %s cyc=%0d load=%0d phase=%0d",
                         kname(e.kind), kname(kind), cyc, val, ph, kname(e.kind), e.cyc, e.val, e.ph);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.cd_en === 1'b1)    seen(EV_EN, int'(bus.cd_load), int'(bus.phase));
        if (bus.cd_clear === 1'b1) seen(EV_CLR, 0, 0);
        if (bus.seq_done === 1'b1) seen(EV_DONE, 0, 0);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_%s: %0d expected events never seen, next at cyc=%0d",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int c, input logic ab);
        go_to(c);
        bus.start = 1'b1;
        bus.abort = ab;
        go_to(c + 1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int s;
        int s2;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.phase_secs = '0;

        go_to(2);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cd_en", int'(bus.cd_en), 0);
        chk("rst_cd_load", int'(bus.cd_load), 0);
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_seq_done", int'(bus.seq_done), 0);
        chk("rst_cd_clear", int'(bus.cd_clear), 0);
        go_to(3);
        reset = 1'b0;

        // Basic run {3,5,2,1}
        s = 10;
        bus.phase_secs = pk(3, 5, 2, 1);
        push(EV_EN, s + 2, 3, 0);
        push(EV_EN, s + 17, 5, 1);
        push(EV_EN, s + 40, 2, 2);
        push(EV_EN, s + 51, 1, 3);
        push(EV_DONE, s + 58, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 57);
        chk("basic_busy_check", int'(bus.busy), 1);
        chk("basic_phase_clamp", int'(bus.phase), 3);
        go_to(s + 59);
        chk("basic_idle", int'(bus.busy), 0);
        go_to(s + 62);
        drained("basic");

        // Skipped phases {0,4,0,0}
        s = 80;
        bus.phase_secs = pk(0, 4, 0, 0);
        push(EV_EN, s + 3, 4, 1);
        push(EV_DONE, s + 24, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 1);
        chk("skip_phase0", int'(bus.phase), 0);
        go_to(s + 2);
        chk("skip_phase1", int'(bus.phase), 1);
        go_to(s + 28);
        drained("skip");

        // All zero durations
        s = 120;
        bus.phase_secs = pk(0, 0, 0, 0);
        push(EV_DONE, s + 6, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 5);
        chk("zero_busy", int'(bus.busy), 1);
        go_to(s + 7);
        chk("zero_idle", int'(bus.busy), 0);
        go_to(s + 9);
        drained("zeros");

        // Done held high: level from before start, and 5-cycle holds, advance once per rise
        s = 140;
        go_to(s - 4);
        done_drv  = 1'b1;
        use_model = 1'b0;
        bus.phase_secs = pk(7, 9, 0, 0);
        push(EV_EN, s + 2, 7, 0);
        push(EV_EN, s + 12, 9, 1);
        push(EV_DONE, s + 24, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 6);
        done_drv = 1'b0;
        go_to(s + 8);
        chk("hold_no_advance", int'(bus.phase), 0);
        go_to(s + 10);
        done_drv = 1'b1;
        go_to(s + 14);
        chk("hold_one_advance", int'(bus.phase), 1);
        go_to(s + 15);
        done_drv = 1'b0;
        go_to(s + 20);
        done_drv = 1'b1;
        go_to(s + 25);
        done_drv = 1'b0;
        go_to(s + 28);
        drained("hold");

        // Abort in WAIT of phase 1, stray done afterwards, then fresh start
        s = 200;
        use_model = 1'b1;
        bus.phase_secs = pk(1, 6, 2, 0);
        push(EV_EN, s + 2, 1, 0);
        push(EV_EN, s + 9, 6, 1);
        push(EV_CLR, s + 16, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 15);
        bus.abort = 1'b1;
        go_to(s + 16);
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        go_to(s + 17);
        chk("abort_clear_once", int'(bus.cd_clear), 0);
        done_drv  = 1'b0;
        use_model = 1'b0;
        go_to(s + 20);
        done_drv = 1'b1;
        go_to(s + 22);
        done_drv = 1'b0;
        go_to(s + 23);
        chk("abort_stray_done", int'(bus.busy), 0);
        drained("abort");
        s2 = s + 26;
        use_model = 1'b1;
        bus.phase_secs = pk(2, 0, 0, 0);
        push(EV_EN, s2 + 2, 2, 0);
        push(EV_DONE, s2 + 16, 0, 0);
        pulse_start(s2, 1'b0);
        go_to(s2 + 20);
        drained("restart");

        // start+abort together in IDLE
        s = 260;
        bus.phase_secs = pk(5, 5, 5, 5);
        pulse_start(s, 1'b1);
        chk("sa_idle_busy1", int'(bus.busy), 0);
        go_to(s + 3);
        chk("sa_idle_busy3", int'(bus.busy), 0);
        drained("start_abort");

        // start pulses and phase_secs changes while busy are ignored
        s = 270;
        bus.phase_secs = pk(2, 1, 0, 0);
        push(EV_EN, s + 2, 2, 0);
        push(EV_EN, s + 13, 1, 1);
        push(EV_DONE, s + 22, 0, 0);
        pulse_start(s, 1'b0);
        go_to(s + 5);
        bus.phase_secs = pk(9, 9, 9, 9);
        pulse_start(s + 5, 1'b0);
        pulse_start(s + 14, 1'b0);
        chk("busy_load_kept", int'(bus.cd_load), 1);
        go_to(s + 25);
        drained("busy_ignore");

        // Synchronous reset during LOAD
        s = 310;
        bus.phase_secs = pk(3, 0, 0, 0);
        push(EV_EN, s + 2, 3, 0);
        pulse_start(s, 1'b0);
        go_to(s + 2);
        reset = 1'b1;
        go_to(s + 3);
        chk("rl_busy", int'(bus.busy), 0);
        chk("rl_cd_en", int'(bus.cd_en), 0);
        chk("rl_cd_load", int'(bus.cd_load), 0);
        chk("rl_phase", int'(bus.phase), 0);
        chk("rl_seq_done", int'(bus.seq_done), 0);
        chk("rl_cd_clear", int'(bus.cd_clear), 0);
        reset = 1'b0;
        go_to(s + 6);
        drained("reset_load");
        s2 = s + 8;
        bus.phase_secs = pk(1, 0, 0, 0);
        push(EV_EN, s2 + 2, 1, 0);
        push(EV_DONE, s2 + 12, 0, 0);
        pulse_start(s2, 1'b0);
        go_to(s2 + 15);
        drained("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
